// File: rtl/flag_pkg.sv
// ============================================================================
//  Module   : flag_pkg
//  Brief    : Shared flag bit indices, default width and flag vector type.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package flag_pkg;

    localparam int NUM_FLAGS_DEF = 3;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef logic [NUM_FLAGS_DEF-1:0] flags_t;

endpackage

`default_nettype wire

// File: rtl/flag_stack.sv
// ============================================================================
//  Module   : flag_stack
//  Brief    : LIFO of flag snapshots with push, pop and swap plus occupancy.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module flag_stack
    import flag_pkg::*;
#(
    parameter  int WIDTH = NUM_FLAGS_DEF,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             restore,
    output logic             op_err,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign cnt     = cnt_q;

    // Index arithmetic only matters while the matching operation is legal.
    assign top_idx = IDX_W'(cnt_q - CNT_W'(1));
    assign wr_idx  = IDX_W'(cnt_q);

    assign do_push = push && !pop && !full;
    assign do_pop  = pop && !push && !empty;
    assign do_swap = push && pop && !empty;

    assign restore = do_pop || do_swap;
    assign op_err  = (push && !pop && full) || (pop && empty);
    assign top     = mem_q[top_idx];

    always_comb begin
        cnt_d = cnt_q;
        mem_d = mem_q;
        if (do_push) begin
            cnt_d         = cnt_q + CNT_W'(1);
            mem_d[wr_idx] = din;
        end else if (do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (do_swap) begin
            mem_d[top_idx] = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Slots at or above the count are never read, so storage needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

`default_nettype wire

// File: rtl/flag_file.sv
// ============================================================================
//  Module   : flag_file
//  Brief    : Condition-flag register with masked writes, save/restore stack
//             and sticky stack error. Option macro: FLAG_FILE_FWD_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module flag_file
    import flag_pkg::*;
#(
    parameter int NUM_FLAGS   = NUM_FLAGS_DEF,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_FLAGS-1:0]               flags_in,
    input  logic [NUM_FLAGS-1:0]               flag_we,
    input  logic                               push,
    input  logic                               pop,
    input  logic                               err_clr,
    output logic [NUM_FLAGS-1:0]               flags_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_cnt,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               stack_err
);

    logic [NUM_FLAGS-1:0] flag_q;
    logic [NUM_FLAGS-1:0] flag_d;
    logic                 err_q;
    logic                 err_d;

    logic [NUM_FLAGS-1:0] stack_top;
    logic                 restore;
    logic                 op_err;

    flag_stack #(
        .WIDTH (NUM_FLAGS),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .din     (flag_q),
        .top     (stack_top),
        .restore (restore),
        .op_err  (op_err),
        .cnt     (stack_cnt),
        .full    (stack_full),
        .empty   (stack_empty)
    );

    always_comb begin
        flag_d = flag_q;
        err_d  = err_q;
        if (restore) begin
            flag_d = stack_top;
        end else begin
            flag_d = (flag_q & ~flag_we) | (flags_in & flag_we);
        end
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (op_err) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= '0;
            err_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            err_q  <= err_d;
        end
    end

    assign stack_err = err_q;

    generate
        for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_out
`ifdef FLAG_FILE_FWD_EN
            // Bypass is gated by rst_n so outputs read zero throughout reset.
            assign flags_out[i] = (rst_n && flag_we[i] && !restore) ? flags_in[i] : flag_q[i];
`else
            assign flags_out[i] = flag_q[i];
`endif
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_flag_file.sv
// ============================================================================
//  Module   : tb_flag_file
//  Brief    : Directed self-checking bench for flag_file (default parameters).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_flag_file;

    logic       clk;
    logic       rst_n;
    logic [2:0] flags_in;
    logic [2:0] flag_we;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [2:0] flags_out;
    logic [2:0] stack_cnt;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    int n_checks;
    int n_pass;

    flag_file #(
        .NUM_FLAGS   (3),
        .STACK_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flags_in    (flags_in),
        .flag_we     (flag_we),
        .push        (push),
        .pop         (pop),
        .err_clr     (err_clr),
        .flags_out   (flags_out),
        .stack_cnt   (stack_cnt),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] fi, input logic [2:0] we,
                         input logic pu, input logic po, input logic ec);
        flags_in = fi;
        flag_we  = we;
        push     = pu;
        pop      = po;
        err_clr  = ec;
    endtask

    // Apply the driven inputs on one edge, then return to idle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
        drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b1;
        drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        #2 rst_n = 1'b0;
        #1;
        check("rst_flags", 32'(flags_out), 32'h0);
        check("rst_cnt",   32'(stack_cnt), 32'h0);
        check("rst_empty", 32'(stack_empty), 32'h1);
        check("rst_full",  32'(stack_full), 32'h0);
        check("rst_err",   32'(stack_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic full-mask write
        @(negedge clk);
        drive(3'b101, 3'b111, 1'b0, 1'b0, 1'b0);
        #1;
`ifdef FLAG_FILE_FWD_EN
        check("fwd_same_cycle", 32'(flags_out), 32'h5);
`else
        check("no_fwd_same_cycle", 32'(flags_out), 32'h0);
`endif
        tick();
        check("write_101", 32'(flags_out), 32'h5);

        // Partial mask
        drive(3'b111, 3'b111, 1'b0, 1'b0, 1'b0); tick();
        drive(3'b000, 3'b010, 1'b0, 1'b0, 1'b0); tick();
        check("mask_010", 32'(flags_out), 32'h5);

        // Push with concurrent write, then pop restores
        drive(3'b100, 3'b111, 1'b0, 1'b0, 1'b0); tick();
        drive(3'b011, 3'b111, 1'b1, 1'b0, 1'b0); tick();
        check("push_reg", 32'(flags_out), 32'h3);
        check("push_cnt", 32'(stack_cnt), 32'h1);
        check("push_nempty", 32'(stack_empty), 32'h0);
        tick();
        drive(3'b000, 3'b111, 1'b0, 1'b1, 1'b0); tick();
        check("pop_reg", 32'(flags_out), 32'h4);
        check("pop_cnt", 32'(stack_cnt), 32'h0);
        check("pop_empty", 32'(stack_empty), 32'h1);

        // Underflow: write still applies, error sticky, error beats clear
        drive(3'b001, 3'b001, 1'b0, 1'b1, 1'b0); tick();
        check("uflow_err", 32'(stack_err), 32'h1);
        check("uflow_reg", 32'(flags_out), 32'h5);
        check("uflow_cnt", 32'(stack_cnt), 32'h0);
        tick();
        check("err_sticky", 32'(stack_err), 32'h1);
        drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b1); tick();
        check("err_beats_clr", 32'(stack_err), 32'h1);
        drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b1); tick();
        check("err_clr", 32'(stack_err), 32'h0);

        // Swap: cnt=2, top=001, reg=110
        drive(3'b001, 3'b111, 1'b1, 1'b0, 1'b0); tick();
        drive(3'b110, 3'b111, 1'b1, 1'b0, 1'b0); tick();
        check("pre_swap_reg", 32'(flags_out), 32'h6);
        check("pre_swap_cnt", 32'(stack_cnt), 32'h2);
        drive(3'b111, 3'b111, 1'b1, 1'b1, 1'b0); tick();
        check("swap_reg", 32'(flags_out), 32'h1);
        check("swap_cnt", 32'(stack_cnt), 32'h2);
        check("swap_err", 32'(stack_err), 32'h0);
        drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0); tick();
        check("swap_top", 32'(flags_out), 32'h6);
        drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0); tick();
        check("pop_bottom", 32'(flags_out), 32'h5);
        check("pop_bottom_cnt", 32'(stack_cnt), 32'h0);

        // Fill to depth, then overflow
        drive(3'b001, 3'b111, 1'b1, 1'b0, 1'b0); tick();
        drive(3'b010, 3'b111, 1'b1, 1'b0, 1'b0); tick();
        drive(3'b011, 3'b111, 1'b1, 1'b0, 1'b0); tick();
        check("cnt3_nfull", 32'(stack_full), 32'h0);
        drive(3'b100, 3'b111, 1'b1, 1'b0, 1'b0); tick();
        check("full", 32'(stack_full), 32'h1);
        check("full_cnt", 32'(stack_cnt), 32'h4);
        drive(3'b111, 3'b111, 1'b1, 1'b0, 1'b0); tick();
        check("oflow_cnt", 32'(stack_cnt), 32'h4);
        check("oflow_err", 32'(stack_err), 32'h1);
        check("oflow_reg", 32'(flags_out), 32'h7);
        drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b1); tick();
        check("oflow_clr", 32'(stack_err), 32'h0);
        drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0); tick();
        check("pop_e3", 32'(flags_out), 32'h3);
        drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0); tick();
        check("pop_e2", 32'(flags_out), 32'h2);
        check("pop_e2_cnt", 32'(stack_cnt), 32'h2);
        drive(3'b000, 3'b000, 1'b1, 1'b0, 1'b0); tick();
        check("cnt3", 32'(stack_cnt), 32'h3);

        // Asynchronous reset in the middle of a push
        @(negedge clk);
        drive(3'b111, 3'b111, 1'b1, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_flags", 32'(flags_out), 32'h0);
        check("arst_cnt", 32'(stack_cnt), 32'h0);
        check("arst_empty", 32'(stack_empty), 32'h1);
        @(posedge clk);
        #1;
        check("arst_hold_cnt", 32'(stack_cnt), 32'h0);
        drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_flags", 32'(flags_out), 32'h0);
        drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0); tick();
        check("post_rst_uflow", 32'(stack_err), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/flag_file.md
FLAG_FILE -- requirements
Module: flag_file

Interface
REQ-001 Parameter NUM_FLAGS, default 3: number of condition flags held; bit 2 = N, bit 1 = Z, bit 0 = V at the default.
REQ-002 Parameter STACK_DEPTH, default 4: number of flag snapshots the save stack holds; SHALL be >= 2.
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port flags_in  input  NUM_FLAGS: new flag values produced by the ALU.
REQ-006 Port flag_we  input  NUM_FLAGS: per-bit write mask; only bits set SHALL be updated from flags_in.
REQ-007 Port push  input  1: save the current flag register onto the stack.
REQ-008 Port pop  input  1: restore the flag register from the top of the stack.
REQ-009 Port err_clr  input  1: clear the sticky error.
REQ-010 Port flags_out  output  NUM_FLAGS: current flag values.
REQ-011 Port stack_cnt  output  $clog2(STACK_DEPTH+1): number of occupied stack entries.
REQ-012 Port stack_full / stack_empty  output  1 each: stack_cnt == STACK_DEPTH / stack_cnt == 0.
REQ-013 Port stack_err  output  1: sticky overflow/underflow indicator.

Function
REQ-014 Flag register: each bit i SHALL load flags_in[i] when flag_we[i]=1 and no pop is taking effect; otherwise it SHALL hold.
REQ-015 Push (pop=0, not full): entry[cnt] <= the flag register value before this cycle's write; cnt += 1; the flag_we write proceeds in the same cycle.
REQ-016 Pop (push=0, not empty): flag register <= entry[cnt-1] for all bits, overriding flag_we; cnt -= 1.
REQ-017 Push and pop in the same cycle with stack not empty: swap; the flag register takes the top entry, the top entry takes the old register value, and cnt is unchanged.
REQ-018 Push when full, pop when empty, or push+pop when empty: no stack or flag-register change from the push/pop; stack_err <= 1; a flag_we write still applies to the register.
REQ-019 stack_err SHALL stay set until err_clr=1 or reset; if an error and err_clr occur in the same cycle, the error wins.
REQ-020 stack_full, stack_empty and stack_cnt SHALL be registered-state derived, with no combinational path from push/pop.
REQ-021 Entries at or above stack_cnt are don't-care and SHALL NOT be observable.

Reset
REQ-022 On rst_n=0: flag register = 0, stack_cnt = 0, stack_empty = 1, stack_full = 0, stack_err = 0, and flags_out = 0 immediately (asynchronously).
REQ-023 Stack entry contents need no reset.
REQ-024 Reset asserted mid-push or mid-pop SHALL discard the operation entirely.

Configuration
REQ-025 Macro FLAG_FILE_FWD_EN defined: flags_out[i] = flags_in[i] when flag_we[i]=1 and no pop is taking effect, else register bit i (same-cycle bypass for branch resolution).
REQ-026 Macro FLAG_FILE_FWD_EN undefined: flags_out = flag register only, so writes are visible one cycle later.

Structure
REQ-027 Shared package flag_pkg SHALL hold the FLAG_N/FLAG_Z/FLAG_V bit indices, the default NUM_FLAGS, and a flags_t typedef.
REQ-028 The LIFO SHALL be a sub-module flag_stack (push/pop/swap, count, full/empty); flag_file SHALL hold the register, masking, bypass and error logic.

Verification
REQ-029 Reset, then flags_in=3'b101, flag_we=3'b111 -> next cycle flags_out=3'b101; with FLAG_FILE_FWD_EN, 3'b101 the same cycle.
REQ-030 Register=3'b111; flag_we=3'b010, flags_in=3'b000 -> flags_out=3'b101.
REQ-031 Register=3'b100; push with flag_we=3'b111, flags_in=3'b011 -> register=3'b011, cnt=1; later pop -> flags_out=3'b100, cnt=0, stack_empty=1.
REQ-032 Push 4 times (depth 4) -> stack_full=1; 5th push -> cnt stays 4, stack_err=1; err_clr -> stack_err=0.
REQ-033 Pop when empty -> stack_err=1, register unchanged; push+pop with cnt=2, top=3'b001, reg=3'b110 -> reg=3'b001, top=3'b110, cnt=2.
REQ-034 rst_n pulled low mid-sequence at cnt=3 -> flags_out=0 and cnt=0 at once, without waiting for a clock edge.
